fifo_rd_ctrl: RTL

Read-side controller for the asynchronous FIFO, living entirely in the read clock domain.
- Owns the binary/Gray read pointer and drives the read address into the shared FIFO memory (combinational read port).
- Generates empty and fill level from the write pointer, which arrives already synchronized into this domain.
- Presents popped words through a registered valid/ready output stage.
- Exports its Gray read pointer to the write-domain synchronizer for full detection.

---
 rtl/fifo_rd_ctrl.sv | 83 ++++++++
 1 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: owns the read pointer, derives
// empty/fill level from the synchronized write pointer, and drives a valid/ready output register.
module fifo_rd_ctrl #(
    parameter  int DATASIZE = 8,
    parameter  int DEPTH    = 16,
    localparam int ADDRSIZE = $clog2(DEPTH)
) (
    input  logic                rd_clk,
    input  logic                rd_rst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DATASIZE-1:0] mem_rdata,
    output logic [ADDRSIZE-1:0] rd_addr,
    output logic [ADDRSIZE:0]   rd_ptr,
    output logic                empty,
    output logic [ADDRSIZE:0]   rd_level,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DATASIZE-1:0] rd_data
);

    function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDRSIZE:0]   rbin_q,     rbin_d;
    logic [ADDRSIZE:0]   rd_ptr_q,   rd_ptr_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATASIZE-1:0] rd_data_q,  rd_data_d;
    logic [ADDRSIZE:0]   rbin_inc;
    logic                fetch;

    assign rd_addr  = rbin_q[ADDRSIZE-1:0];
    assign rd_ptr   = rd_ptr_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

    // The mod-2^(ADDRSIZE+1) subtraction handles pointer wrap without extra logic.
    assign empty    = (rd_ptr_q == rq2_wptr);
    assign rd_level = gray2bin(rq2_wptr) - rbin_q;

    assign rbin_inc = rbin_q + (ADDRSIZE+1)'(1);
    assign fetch    = !empty && (!rd_valid_q || rd_ready);

    always_comb begin
        rbin_d     = rbin_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        if (fetch) begin
            rd_data_d  = mem_rdata;
            rd_valid_d = 1'b1;
            rbin_d     = rbin_inc;
            rd_ptr_d   = bin2gray(rbin_inc);
        end else if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end
    end

    // Output register stage
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            rbin_q     <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rbin_q     <= rbin_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule
